// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and the decoder.
//   state_t            : sequencer FSM state encoding
//   OP_*               : opcodes the execute path supports
//   PC_STEP            : program-counter increment per retired instruction
//   is_supported_opcode: true when an opcode may proceed to EXECUTE
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  localparam logic [6:0]  OP_REG_REG         = 7'b0110011;
  localparam logic [6:0]  OP_IMMEDIATE       = 7'b0010011;
  localparam logic [6:0]  OP_UPPER_IMMEDIATE = 7'b0110111;
  localparam logic [31:0] PC_STEP            = 32'd4;

  function automatic logic is_supported_opcode(input logic [6:0] op);
    return (op == OP_REG_REG) || (op == OP_IMMEDIATE) || (op == OP_UPPER_IMMEDIATE);
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Fetch wait counter.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : force count to zero (held while not fetching)
//   enable   : one fetch cycle elapsed without an acknowledge
//   expired  : this enabled cycle is the TIMEOUT-th cycle without acknowledge
module fetch_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The count reaches TIMEOUT on the edge closing this cycle; flag it now so
  // the FSM can leave FETCH on that same edge.
  assign expired = enable && (count_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: IDLE -> FETCH -> DECODE -> EXECUTE ->
// WRITEBACK -> FETCH ..., with a sticky HALT on illegal opcode or fetch timeout.
//   clk, rst        : clock, asynchronous active-high reset
//   run_in          : start request, honoured only in IDLE
//   imem_req/addr   : fetch request and address (address = pc_out)
//   imem_ack/rdata  : fetch acknowledge and instruction word
//   instr_out       : instruction register feeding the external decoder
//   opcode_in       : decoder opcode for instr_out
//   write_enable_in : decoder register-write request for instr_out
//   alu_en, rf_we   : execute and register-file write strobes
//   pc_out          : program counter
//   instret_out     : retired instruction count
//   illegal_out     : sticky illegal-opcode fault
//   fetch_err_out   : sticky fetch-timeout fault
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  input  logic [6:0]  opcode_in,
  input  logic        write_enable_in,
  output logic        alu_en,
  output logic        rf_we,
  output logic [31:0] pc_out,
  output logic [31:0] instret_out,
  output logic        illegal_out,
  output logic        fetch_err_out
);

  state_t      state_q,   state_d;
  logic [31:0] pc_q,      pc_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] instr_q,   instr_d;
  logic        illegal_q, illegal_d;
  logic        ferr_q,    ferr_d;
  logic        fetch_expired;

  // Timer only runs in FETCH; holding it clear elsewhere gives a fresh count
  // on every FETCH entry.
  fetch_timer #(
    .TIMEOUT (FETCH_TIMEOUT)
  ) u_fetch_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != ST_FETCH),
    .enable  ((state_q == ST_FETCH) && !imem_ack),
    .expired (fetch_expired)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    instr_d   = instr_q;
    illegal_d = illegal_q;
    ferr_d    = ferr_q;
    case (state_q)
      ST_IDLE: begin
        if (run_in) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // An acknowledge wins over a timeout landing in the same cycle.
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_DECODE;
        end else if (fetch_expired) begin
          ferr_d  = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (is_supported_opcode(opcode_in)) begin
          state_d = ST_EXECUTE;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_EXECUTE: begin
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        pc_d      = pc_q + PC_STEP;
        instret_d = instret_q + 32'd1;
        state_d   = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      instret_q <= 32'd0;
      instr_q   <= 32'd0;
      illegal_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
      ferr_q    <= ferr_d;
    end
  end

  // Strobes decode from the state register only, so imem_ack never reaches
  // imem_req combinationally.
  assign imem_req      = (state_q == ST_FETCH);
  assign imem_addr     = pc_q;
  assign alu_en        = (state_q == ST_EXECUTE);
  assign rf_we         = (state_q == ST_WRITEBACK) && write_enable_in;
  assign instr_out     = instr_q;
  assign pc_out        = pc_q;
  assign instret_out   = instret_q;
  assign illegal_out   = illegal_q;
  assign fetch_err_out = ferr_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios followed by randomized
// instruction streams, checked cycle by cycle against a transaction-level
// model of the architectural state (pc, retired count, instruction, faults).
module tb_cpu_sequencer;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam int          TMO    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [6:0]  opcode_in;
  logic        write_enable_in;
  logic        alu_en;
  logic        rf_we;
  logic [31:0] pc_out;
  logic [31:0] instret_out;
  logic        illegal_out;
  logic        fetch_err_out;

  int checks = 0;
  int errors = 0;

  // Architectural model
  logic [31:0] pc_m, instret_m, instr_m;
  logic        ill_m, ferr_m;

  cpu_sequencer #(
    .RESET_PC      (RST_PC),
    .FETCH_TIMEOUT (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .run_in          (run_in),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_out       (instr_out),
    .opcode_in       (opcode_in),
    .write_enable_in (write_enable_in),
    .alu_en          (alu_en),
    .rf_we           (rf_we),
    .pc_out          (pc_out),
    .instret_out     (instret_out),
    .illegal_out     (illegal_out),
    .fetch_err_out   (fetch_err_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_arch(input string tag);
    chk({tag, "_pc"},      pc_out,        pc_m);
    chk({tag, "_instret"}, instret_out,   instret_m);
    chk({tag, "_instr"},   instr_out,     instr_m);
    chk({tag, "_illegal"}, illegal_out,   ill_m);
    chk({tag, "_ferr"},    fetch_err_out, ferr_m);
  endtask

  function automatic bit legal_op(input logic [6:0] op);
    return (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0110111);
  endfunction

  // Reset asserted mid-cycle: outputs must clear before the next clock edge.
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    run_in = 1'b0;
    imem_ack = 1'b0;
    #1;
    pc_m = RST_PC; instret_m = 32'd0; instr_m = 32'd0; ill_m = 1'b0; ferr_m = 1'b0;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_alu", alu_en, 1'b0);
    chk("rst_rfwe", rf_we, 1'b0);
    chk_arch("rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick;
    chk("idle_req", imem_req, 1'b0);
    chk("idle_rfwe", rf_we, 1'b0);
    chk_arch("idle");
  endtask

  task automatic start;
    run_in = 1'b1;
    tick;
    run_in = 1'b0;
  endtask

  task automatic halt_hold;
    for (int i = 0; i < 3; i++) begin
      run_in = 1'($urandom_range(0, 1));
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      opcode_in = 7'b0110011;
      tick;
      chk("halt_req", imem_req, 1'b0);
      chk("halt_alu", alu_en, 1'b0);
      chk("halt_rfwe", rf_we, 1'b0);
      chk_arch("halt");
    end
    imem_ack = 1'b0;
  endtask

  // status: 0 = retired, back in FETCH; 1 = halted; 2 = reset applied in EXECUTE
  task automatic run_instr(input int wait_n, input logic [31:0] word, input logic [6:0] op,
                           input logic we, input bit rst_in_exec, output int status);
    bit accepted;
    accepted = 1'b0;
    status = 0;
    for (int k = 0; k < TMO && !accepted; k++) begin
      chk("fetch_req", imem_req, 1'b1);
      chk("fetch_addr", imem_addr, pc_m);
      chk("fetch_alu", alu_en, 1'b0);
      run_in = 1'($urandom_range(0, 1));
      if (k == wait_n) begin
        imem_ack = 1'b1;
        imem_rdata = word;
        instr_m = word;
        accepted = 1'b1;
      end else begin
        imem_ack = 1'b0;
        imem_rdata = $urandom;
      end
      tick;
    end
    if (!accepted) begin
      ferr_m = 1'b1;
      status = 1;
      chk("tmo_req", imem_req, 1'b0);
      chk_arch("tmo");
    end else begin
      chk("dec_req", imem_req, 1'b0);
      chk("dec_alu", alu_en, 1'b0);
      chk("dec_rfwe", rf_we, 1'b0);
      chk_arch("dec");
      opcode_in = op;
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      tick;
      if (!legal_op(op)) begin
        ill_m = 1'b1;
        status = 1;
        chk("ill_alu", alu_en, 1'b0);
        chk("ill_req", imem_req, 1'b0);
        chk_arch("ill");
      end else begin
        chk("exe_alu", alu_en, 1'b1);
        chk("exe_rfwe", rf_we, 1'b0);
        chk("exe_req", imem_req, 1'b0);
        chk_arch("exe");
        if (rst_in_exec) begin
          do_reset;
          status = 2;
        end else begin
          write_enable_in = we;
          imem_ack = 1'($urandom_range(0, 1));
          imem_rdata = $urandom;
          tick;
          chk("wb_alu", alu_en, 1'b0);
          chk("wb_rfwe", rf_we, we);
          chk("wb_req", imem_req, 1'b0);
          chk_arch("wb");
          imem_ack = 1'b0;
          tick;
          write_enable_in = 1'($urandom_range(0, 1));
          pc_m = pc_m + 32'd4;
          instret_m = instret_m + 32'd1;
          chk_arch("ret");
        end
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic recover(input int status);
    if (status == 1) begin
      halt_hold;
      do_reset;
      start;
    end else if (status == 2) begin
      start;
    end
  endtask

  initial begin
    int st;
    int w;
    logic [6:0] op;
    logic [6:0] ops [3];
    rst = 1'b1;
    run_in = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    opcode_in = 7'd0;
    write_enable_in = 1'b0;
    ops[0] = 7'b0110011;
    ops[1] = 7'b0010011;
    ops[2] = 7'b0110111;

    do_reset;
    // IDLE without run_in stays idle
    tick;
    chk("idle_hold_req", imem_req, 1'b0);
    start;

    // addi, ack on first fetch cycle; pc wraps from FFFF_FFFC to 0
    run_instr(0, 32'h00500093, 7'b0010011, 1'b1, 1'b0, st);
    chk("wrap_pc", pc_out, 32'h0000_0000);
    chk("first_instret", instret_out, 32'd1);
    // ack delayed 5 cycles
    run_instr(5, 32'h002081b3, 7'b0110011, 1'b1, 1'b0, st);
    // ack in the same cycle the timer would expire
    run_instr(TMO - 1, 32'h123452b7, 7'b0110111, 1'b0, 1'b0, st);
    chk("late_ack_ferr", fetch_err_out, 1'b0);
    // illegal opcode
    run_instr(1, 32'h00000063, 7'b1100011, 1'b1, 1'b0, st);
    chk("ill_status", st, 1);
    recover(st);
    // fetch timeout
    run_instr(TMO, 32'h0, 7'b0110011, 1'b1, 1'b0, st);
    chk("tmo_status", st, 1);
    recover(st);
    // reset during EXECUTE
    run_instr(2, 32'h00a00113, 7'b0010011, 1'b1, 1'b1, st);
    recover(st);
    chk("post_rst_addr", imem_addr, RST_PC);

    // randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) w = $urandom_range(0, 20);
      else w = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) begin
        op = 7'($urandom);
        while (legal_op(op)) op = 7'($urandom);
      end else begin
        op = ops[$urandom_range(0, 2)];
      end
      run_instr(w, $urandom, op, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), st);
      recover(st);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter FETCH_TIMEOUT, default 16, maximum FETCH cycles without imem_ack before fault.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 run_in  input  1  start enable, sampled only in IDLE.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_addr  output  32  fetch address, equal to pc_out.
REQ-008 imem_ack  input  1  fetch data valid this cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 instr_out  output  32  instruction register, drives the combinational decoder.
REQ-011 opcode_in  input  7  decoder opcode field for instr_out.
REQ-012 write_enable_in  input  1  decoder register-write request for instr_out.
REQ-013 alu_en  output  1  one-cycle execute strobe.
REQ-014 rf_we  output  1  one-cycle register-file write strobe.
REQ-015 pc_out  output  32  current program counter.
REQ-016 instret_out  output  32  retired-instruction count.
REQ-017 illegal_out  output  1  sticky illegal-opcode fault.
REQ-018 fetch_err_out  output  1  sticky fetch-timeout fault.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-020 IDLE SHALL go to FETCH on run_in=1, else remain.
REQ-021 FETCH SHALL assert imem_req=1 with imem_addr=pc_out every cycle until imem_ack=1.
REQ-022 On imem_ack=1 in FETCH, instr_out SHALL load imem_rdata and state SHALL go to DECODE next cycle; imem_req SHALL deassert from that next cycle.
REQ-023 imem_ack outside FETCH SHALL be ignored; instr_out SHALL change only on an accepted FETCH ack.
REQ-024 A FETCH wait counter SHALL clear on FETCH entry and increment each FETCH cycle without ack; reaching FETCH_TIMEOUT SHALL go to HALT and set fetch_err_out=1.
REQ-025 Ack in the same cycle the counter reaches FETCH_TIMEOUT SHALL take priority (instruction accepted, no fault).
REQ-026 DECODE SHALL last one cycle; opcode_in in {7'b0110011, 7'b0010011, 7'b0110111} SHALL go to EXECUTE; any other value SHALL go to HALT and set illegal_out=1.
REQ-027 EXECUTE SHALL assert alu_en=1 for exactly one cycle, then go to WRITEBACK.
REQ-028 WRITEBACK SHALL assert rf_we=write_enable_in for one cycle, advance pc_out by 4 (modulo 2^32), increment instret_out (modulo 2^32), then go to FETCH.
REQ-029 Minimum instruction latency SHALL be 4 cycles (ack in first FETCH cycle); each wait cycle adds one.
REQ-030 HALT SHALL be absorbing: all strobes 0, pc_out/instret_out/instr_out frozen; exit only via rst.
REQ-031 alu_en, rf_we, imem_req SHALL be 0 in every state not named above for them.
REQ-032 run_in SHALL have no effect outside IDLE.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE, pc_out=RESET_PC, instret_out=0, instr_out=0, wait counter=0, illegal_out=0, fetch_err_out=0, imem_req=0, alu_en=0, rf_we=0.
REQ-034 rst asserted mid-instruction SHALL abandon it: no rf_we, no pc or instret update.
REQ-035 After rst deasserts, the first FETCH SHALL use address RESET_PC.

Structure
REQ-036 State encoding, supported opcode constants (REG_REG, IMMEDIATE, UPPER_IMMEDIATE) and PC_STEP=4 SHALL live in a shared package used by this block and the decoder.
REQ-037 The FETCH wait/timeout counter SHALL be a sub-module named fetch_timer (clear, enable, expired).
REQ-038 Outputs SHALL be registered or decoded from state only; no combinational path from imem_ack to imem_req.

Verification
REQ-039 Reset, run_in=1, ack on first FETCH cycle with 32'h00500093 (addi) -> alu_en at cycle 3, rf_we=1 at cycle 4, pc_out=4, instret_out=1.
REQ-040 Ack delayed 5 cycles -> imem_req held 6 cycles at address 0, instruction latency 9 cycles, no fault.
REQ-041 Fetch with opcode 7'b1100011 -> no alu_en, HALT, illegal_out=1, pc_out unchanged.
REQ-042 No ack for 16 FETCH cycles -> fetch_err_out=1, imem_req=0 thereafter; ack on cycle 16 instead -> normal DECODE.
REQ-043 pc_out forced to 32'hFFFF_FFFC via RESET_PC, one instruction retired -> pc_out=0.
REQ-044 rst asserted during EXECUTE -> outputs reset asynchronously, no rf_we pulse, next FETCH address RESET_PC.
